por_rst_seq: RTL and testbench

- Sits directly downstream of the POR macro in the digital domain.
- Clocked by `osc_ck`; `porb` is its asynchronous reset.
- Releases NUM_DOM block resets in a fixed order (domain 0 first) with a programmable delay per stage.
- Monitors `pwup_filt` while running: a debounced brownout or a software reset request re-asserts every domain reset and restarts the sequence. Brownout events are counted for debug.

---
 rtl/por_rst_seq.sv | 189 ++++++++++++++++++
 tb/tb_por_rst_seq.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/por_rst_seq.sv
// Power-on reset sequencer: releases NUM_DOM block resets in order with a
// programmable per-stage delay and re-asserts them all on brownout or software request.
module por_rst_seq #(
    parameter int NUM_DOM  = 4,
    parameter int DLY_W    = 8,
    parameter int FILT_CYC = 4
) (
    input  logic                       osc_ck,
    input  logic                       porb,
    input  logic                       pwup_filt,
    input  logic                       sw_rst_req,
    input  logic [NUM_DOM*DLY_W-1:0]   dly_cfg,
    output logic [NUM_DOM-1:0]         rstb_out,
    output logic                       seq_done,
    output logic [7:0]                 bo_count,
    output logic [2:0]                 seq_state
);

    localparam int STG_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
    localparam logic [STG_W-1:0] LAST_STG  = STG_W'(NUM_DOM - 1);
    localparam logic [3:0]       FILT_LAST = 4'(FILT_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_STAGE = 3'd1,
        ST_DONE  = 3'd2,
        ST_HOLD  = 3'd3
    } state_e;

    logic [1:0]         rst_sync_q;
    logic               rst_n_i;
    logic [1:0]         pwup_sync_q;
    logic               pwup_s;
    logic [3:0]         filt_cnt_q, filt_cnt_d;
    logic               pwup_ok_q, pwup_ok_d;
    state_e             state_q, state_d;
    logic [STG_W-1:0]   stage_q, stage_d;
    logic [DLY_W-1:0]   dly_cnt_q, dly_cnt_d;
    logic [NUM_DOM-1:0] rstb_q, rstb_d;
    logic               seq_done_q, seq_done_d;
    logic [7:0]         bo_q, bo_d;
    logic               abort_s;
    logic               go_s;
    logic               cnt_zero_s;
    logic               last_stage_s;

    function automatic logic [DLY_W-1:0] dly_field(input logic [STG_W-1:0] idx);
        return dly_cfg[idx*DLY_W +: DLY_W];
    endfunction

    // Reset synchronizer: assert with porb immediately, release two edges later
    always_ff @(posedge osc_ck or negedge porb) begin
        if (!porb) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_n_i = rst_sync_q[1];

    // Supply-good synchronizer
    always_ff @(posedge osc_ck or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pwup_sync_q <= 2'b00;
        end else begin
            pwup_sync_q <= {pwup_sync_q[0], pwup_filt};
        end
    end
    assign pwup_s = pwup_sync_q[1];

    // Debounce: flip pwup_ok after FILT_CYC consecutive disagreeing samples
    always_comb begin
        filt_cnt_d = 4'd0;
        pwup_ok_d  = pwup_ok_q;
        if (pwup_s != pwup_ok_q) begin
            if (filt_cnt_q == FILT_LAST) begin
                pwup_ok_d  = pwup_s;
                filt_cnt_d = 4'd0;
            end else begin
                filt_cnt_d = filt_cnt_q + 4'd1;
            end
        end else begin
            filt_cnt_d = 4'd0;
        end
    end

    assign go_s         = pwup_ok_q && !sw_rst_req;
    assign abort_s      = ((state_q == ST_STAGE) || (state_q == ST_DONE)) &&
                          (!pwup_ok_q || sw_rst_req);
    assign cnt_zero_s   = (dly_cnt_q == {DLY_W{1'b0}});
    assign last_stage_s = (stage_q == LAST_STG);

    // State and datapath registers
    always_ff @(posedge osc_ck or negedge rst_n_i) begin
        if (!rst_n_i) begin
            filt_cnt_q <= 4'd0;
            pwup_ok_q  <= 1'b0;
            state_q    <= ST_IDLE;
            stage_q    <= {STG_W{1'b0}};
            dly_cnt_q  <= {DLY_W{1'b0}};
            rstb_q     <= {NUM_DOM{1'b0}};
            seq_done_q <= 1'b0;
            bo_q       <= 8'd0;
        end else begin
            filt_cnt_q <= filt_cnt_d;
            pwup_ok_q  <= pwup_ok_d;
            state_q    <= state_d;
            stage_q    <= stage_d;
            dly_cnt_q  <= dly_cnt_d;
            rstb_q     <= rstb_d;
            seq_done_q <= seq_done_d;
            bo_q       <= bo_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (go_s) state_d = ST_STAGE; else state_d = ST_IDLE;
            ST_STAGE: begin
                if (abort_s) begin
                    state_d = ST_HOLD;
                end else if (cnt_zero_s && last_stage_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_STAGE;
                end
            end
            ST_DONE:  if (abort_s) state_d = ST_HOLD; else state_d = ST_DONE;
            ST_HOLD:  if (go_s) state_d = ST_IDLE; else state_d = ST_HOLD;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output and counter logic; the next field is sampled in the release cycle
    always_comb begin
        stage_d    = stage_q;
        dly_cnt_d  = dly_cnt_q;
        rstb_d     = rstb_q;
        seq_done_d = 1'b0;
        bo_d       = bo_q;
        if (abort_s) begin
            rstb_d = {NUM_DOM{1'b0}};
            if (!pwup_ok_q && (bo_q != 8'hFF)) begin
                bo_d = bo_q + 8'd1;
            end else begin
                bo_d = bo_q;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rstb_d = {NUM_DOM{1'b0}};
                    if (go_s) begin
                        stage_d   = {STG_W{1'b0}};
                        dly_cnt_d = dly_field({STG_W{1'b0}});
                    end else begin
                        stage_d   = stage_q;
                    end
                end
                ST_STAGE: begin
                    if (!cnt_zero_s) begin
                        dly_cnt_d = dly_cnt_q - {{(DLY_W-1){1'b0}}, 1'b1};
                    end else begin
                        rstb_d[stage_q] = 1'b1;
                        if (!last_stage_s) begin
                            stage_d   = stage_q + 1'b1;
                            dly_cnt_d = dly_field(stage_q + 1'b1);
                        end else begin
                            stage_d   = stage_q;
                        end
                    end
                end
                ST_DONE: begin
                    rstb_d     = {NUM_DOM{1'b1}};
                    seq_done_d = 1'b1;
                end
                ST_HOLD: rstb_d = {NUM_DOM{1'b0}};
                default: rstb_d = {NUM_DOM{1'b0}};
            endcase
        end
    end

    assign rstb_out  = rstb_q;
    assign seq_done  = seq_done_q;
    assign bo_count  = bo_q;
    assign seq_state = state_q;

endmodule

// File: tb/tb_por_rst_seq.sv
// Directed bench for por_rst_seq: cold start timing, debounce, software reset,
// brownout counter saturation, async reset and zero-delay sequencing.
module tb_por_rst_seq;

    logic        osc_ck = 1'b0;
    logic        porb;
    logic        pwup_filt;
    logic        sw_rst_req;
    logic [31:0] dly_cfg;
    logic [3:0]  rstb_out;
    logic        seq_done;
    logic [7:0]  bo_count;
    logic [2:0]  seq_state;

    int n_checks = 0;
    int n_fail   = 0;

    por_rst_seq #(.NUM_DOM(4), .DLY_W(8), .FILT_CYC(4)) dut (
        .osc_ck     (osc_ck),
        .porb       (porb),
        .pwup_filt  (pwup_filt),
        .sw_rst_req (sw_rst_req),
        .dly_cfg    (dly_cfg),
        .rstb_out   (rstb_out),
        .seq_done   (seq_done),
        .bo_count   (bo_count),
        .seq_state  (seq_state)
    );

    always #5 osc_ck = ~osc_ck;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge osc_ck);
        @(negedge osc_ck);
    endtask

    // Records the edge index (counted from now) at which each output first rises
    task automatic run_measure(input string tag, input int e0, input int e1,
                               input int e2, input int e3, input int ed);
        int rise[5];
        for (int i = 0; i < 5; i++) rise[i] = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            for (int d = 0; d < 4; d++) begin
                if (rstb_out[d] && rise[d] < 0) rise[d] = k;
            end
            if (seq_done && rise[4] < 0) rise[4] = k;
        end
        check_eq({tag, "_dom0"}, rise[0], e0);
        check_eq({tag, "_dom1"}, rise[1], e1);
        check_eq({tag, "_dom2"}, rise[2], e2);
        check_eq({tag, "_dom3"}, rise[3], e3);
        check_eq({tag, "_done"}, rise[4], ed);
    endtask

    task automatic brownout_event();
        pwup_filt = 1'b0;
        repeat (8) tick();
        pwup_filt = 1'b1;
        repeat (9) tick();
    endtask

    initial begin
        logic found;
        porb       = 1'b0;
        pwup_filt  = 1'b1;
        sw_rst_req = 1'b0;
        dly_cfg    = {8'd3, 8'd0, 8'd5, 8'd2};
        repeat (3) @(negedge osc_ck);

        check_eq("rst_rstb",  rstb_out,  4'h0);
        check_eq("rst_done",  seq_done,  1'b0);
        check_eq("rst_bo",    bo_count,  8'd0);
        check_eq("rst_state", seq_state, 3'd0);

        // Cold start: 2 sync + 2 pwup sync + 4 debounce + 1 IDLE edge => STAGE at edge 9
        porb = 1'b1;
        run_measure("cold", 12, 18, 19, 23, 24);
        check_eq("cold_state", seq_state, 3'd2);
        check_eq("cold_rstb",  rstb_out,  4'hF);

        // Short glitch is filtered
        pwup_filt = 1'b0;
        repeat (3) tick();
        pwup_filt = 1'b1;
        repeat (10) tick();
        check_eq("glitch_rstb",  rstb_out,  4'hF);
        check_eq("glitch_bo",    bo_count,  8'd0);
        check_eq("glitch_state", seq_state, 3'd2);

        // Six-cycle low pulse is a brownout
        pwup_filt = 1'b0;
        repeat (6) tick();
        check_eq("bo_pre_rstb", rstb_out, 4'hF);
        pwup_filt = 1'b1;
        tick();
        check_eq("bo_rstb",  rstb_out,  4'h0);
        check_eq("bo_done",  seq_done,  1'b0);
        check_eq("bo_state", seq_state, 3'd3);
        check_eq("bo_count", bo_count,  8'd1);

        // Software reset while stage 2 is pending
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (rstb_out == 4'b0011) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("sw_reach_stage2", found, 1'b1);
        sw_rst_req = 1'b1;
        tick();
        check_eq("sw_rstb",  rstb_out,  4'h0);
        check_eq("sw_state", seq_state, 3'd3);
        check_eq("sw_bo",    bo_count,  8'd1);
        sw_rst_req = 1'b0;
        run_measure("sw_restart", 5, 11, 12, 16, 17);

        // Brownout counter saturation
        dly_cfg = {8'd0, 8'd0, 8'd50, 8'd0};
        for (int n = 0; n < 253; n++) brownout_event();
        check_eq("bo_254", bo_count, 8'd254);
        for (int n = 0; n < 7; n++) brownout_event();
        check_eq("bo_sat",       bo_count,  8'd255);
        check_eq("sat_rstb",     rstb_out,  4'h1);
        check_eq("sat_state",    seq_state, 3'd1);

        // Async reset in STAGE, no clock edge needed
        #2 porb = 1'b0;
        #1;
        check_eq("async_rstb",  rstb_out,  4'h0);
        check_eq("async_done",  seq_done,  1'b0);
        check_eq("async_bo",    bo_count,  8'd0);
        check_eq("async_state", seq_state, 3'd0);

        // Zero delays: consecutive releases after sync + debounce
        @(negedge osc_ck);
        dly_cfg = 32'd0;
        porb    = 1'b1;
        run_measure("zero_dly", 10, 11, 12, 13, 14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
